bus_sram_responder: RTL and testbench

Memory-side responder for one copperv bus port (instruction or data). It accepts read and write address/data handshakes from the core's master interface, serves them from an internal single-port synchronous SRAM, and returns read data on the rdata channel. Two instances (i-port, d-port) form the simulation/FPGA memory system behind the core.

---
 rtl/bus_sram_responder_pkg.sv | 14 +
 rtl/bus_sram_responder_sram_1rw.sv | 38 +++
 rtl/bus_sram_responder.sv | 149 ++++++++++++++
 tb/tb_bus_sram_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sram_responder_pkg.sv
// Shared definitions for the bus SRAM responder.
//   state_e     : responder FSM states
//   WORD_OFFSET : number of byte-address bits below the word index
package bus_sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_OFFSET = 2;

endpackage

// File: rtl/bus_sram_responder_sram_1rw.sv
// Single-port synchronous SRAM, one access per cycle.
// Read data appears on rdata_o after the edge that samples en_i with we_i low.
// A write does not update rdata_o. No reset: contents and output register
// power up undefined.
//   clk_i   : clock
//   en_i    : access enable
//   we_i    : 1 = write, 0 = read (when en_i)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
module sram_1rw #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 1024
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(depth)-1:0] addr_i,
  input  logic [width-1:0]         wdata_i,
  output logic [width-1:0]         rdata_o
);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Memory-side responder for one bus port (instruction or data).
// Read address, write address and write data are each captured into a
// holding register; an FSM serves complete writes and reads from a
// single-port SRAM, round-robin when both are pending.
//   clk_i / rst_ni              : clock, asynchronous active-low reset
//   raddr_valid_i/ready_o/raddr_i : read address channel (byte address)
//   rdata_valid_o/ready_i/rdata_o : read data channel
//   waddr_valid_i/ready_o/waddr_i : write address channel (byte address)
//   wdata_valid_i/ready_o/wdata_i : write data channel (full word)
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter int unsigned bus_width  = 32,
  parameter int unsigned addr_width = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 raddr_valid_i,
  output logic                 raddr_ready_o,
  input  logic [bus_width-1:0] raddr_i,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [bus_width-1:0] rdata_o,
  input  logic                 waddr_valid_i,
  output logic                 waddr_ready_o,
  input  logic [bus_width-1:0] waddr_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [bus_width-1:0] wdata_i
);

  localparam int unsigned HI = addr_width + WORD_OFFSET - 1;

  logic                  armed_q;
  logic                  ra_full_q, ra_full_d;
  logic                  wa_full_q, wa_full_d;
  logic                  wd_full_q, wd_full_d;
  logic [addr_width-1:0] ra_q, wa_q;
  logic [bus_width-1:0]  wd_q;
  state_e                state_q, state_d;
  logic                  prio_rd_q, prio_rd_d;
  logic [bus_width-1:0]  rdata_q, rdata_d;

  logic                  ra_hs, wa_hs, wd_hs;
  logic                  wr_pend, rd_pend;
  logic                  issue_rd, issue_wr;
  logic                  sram_en, sram_we;
  logic [addr_width-1:0] sram_addr;
  logic [bus_width-1:0]  sram_rdata;

  // Byte-offset and above-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i[bus_width-1:HI+1], raddr_i[WORD_OFFSET-1:0],
                              waddr_i[bus_width-1:HI+1], waddr_i[WORD_OFFSET-1:0]};

  assign raddr_ready_o = armed_q & ~ra_full_q;
  assign waddr_ready_o = armed_q & ~wa_full_q;
  assign wdata_ready_o = armed_q & ~wd_full_q;
  assign rdata_valid_o = (state_q == ST_RESP);
  assign rdata_o       = rdata_q;

  assign ra_hs   = raddr_valid_i & raddr_ready_o;
  assign wa_hs   = waddr_valid_i & waddr_ready_o;
  assign wd_hs   = wdata_valid_i & wdata_ready_o;
  assign wr_pend = wa_full_q & wd_full_q;
  assign rd_pend = ra_full_q;

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    rdata_d   = rdata_q;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = ra_q;
    unique case (state_q)
      ST_IDLE: begin
        // prio_rd_q only matters when both requesters are pending; the
        // winner of a contested grant hands priority to the other side.
        if (wr_pend && (!rd_pend || !prio_rd_q)) begin
          issue_wr  = 1'b1;
          sram_en   = 1'b1;
          sram_we   = 1'b1;
          sram_addr = wa_q;
          if (rd_pend) prio_rd_d = 1'b1;
        end else if (rd_pend) begin
          issue_rd  = 1'b1;
          sram_en   = 1'b1;
          sram_addr = ra_q;
          state_d   = ST_RD;
          if (wr_pend) prio_rd_d = 1'b0;
        end
      end
      ST_RD: begin
        rdata_d = sram_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rdata_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready is low while full, so a capture never coincides with a clear.
    ra_full_d = issue_rd ? 1'b0 : (ra_full_q | ra_hs);
    wa_full_d = issue_wr ? 1'b0 : (wa_full_q | wa_hs);
    wd_full_d = issue_wr ? 1'b0 : (wd_full_q | wd_hs);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q   <= 1'b0;
      ra_full_q <= 1'b0;
      wa_full_q <= 1'b0;
      wd_full_q <= 1'b0;
      ra_q      <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
      state_q   <= ST_IDLE;
      prio_rd_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      armed_q   <= 1'b1;
      ra_full_q <= ra_full_d;
      wa_full_q <= wa_full_d;
      wd_full_q <= wd_full_d;
      if (ra_hs) ra_q <= raddr_i[HI:WORD_OFFSET];
      if (wa_hs) wa_q <= waddr_i[HI:WORD_OFFSET];
      if (wd_hs) wd_q <= wdata_i;
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      rdata_q   <= rdata_d;
    end
  end

  sram_1rw #(
    .width(bus_width),
    .depth(2 ** addr_width)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (sram_en),
    .we_i   (sram_we),
    .addr_i (sram_addr),
    .wdata_i(wd_q),
    .rdata_o(sram_rdata)
  );

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder. A word-array model indexed by
// (byte address / 4) mod 1024 holds expected memory contents; an expected
// round-robin winner is tracked for contested cycles.
module tb_bus_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        raddr_valid, raddr_ready;
  logic [31:0] raddr;
  logic        rdata_valid, rdata_ready;
  logic [31:0] rdata;
  logic        waddr_valid, waddr_ready;
  logic [31:0] waddr;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [1024];
  bit          model_valid [1024];
  bit          model_prio_rd;

  always #5 clk = ~clk;

  bus_sram_responder #(.bus_width(32), .addr_width(10)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .raddr_valid_i(raddr_valid),
    .raddr_ready_o(raddr_ready),
    .raddr_i      (raddr),
    .rdata_valid_o(rdata_valid),
    .rdata_ready_i(rdata_ready),
    .rdata_o      (rdata),
    .waddr_valid_i(waddr_valid),
    .waddr_ready_o(waddr_ready),
    .waddr_i      (waddr),
    .wdata_valid_i(wdata_valid),
    .wdata_ready_o(wdata_ready),
    .wdata_i      (wdata)
  );

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a / 4) % 1024;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int good = 0;
    int cnt  = 0;
    while (good < 3 && cnt < 100) begin
      if (raddr_ready && waddr_ready && wdata_ready && !rdata_valid) good++;
      else good = 0;
      tick();
      cnt++;
    end
    if (good < 3) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, need 3 idle cycles", cnt);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bit ad = 0, dd = 0, ah, dh;
    int cnt = 0;
    waddr = a; wdata = d;
    waddr_valid = 1'b1; wdata_valid = 1'b1;
    while (!(ad && dd) && cnt < 50) begin
      ah = waddr_valid && waddr_ready;
      dh = wdata_valid && wdata_ready;
      tick();
      if (ah) begin ad = 1; waddr_valid = 1'b0; end
      if (dh) begin dd = 1; wdata_valid = 1'b0; end
      cnt++;
    end
    waddr_valid = 1'b0; wdata_valid = 1'b0;
    if (!(ad && dd)) begin
      n_checks++; n_fail++;
      $display("FAIL write_handshake: addr_done=%0d data_done=%0d, required both 1", ad, dd);
    end
    model_mem[word_of(a)]   = d;
    model_valid[word_of(a)] = 1'b1;
  endtask

  // lat = edges from the raddr handshake edge until rdata_valid is seen.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    int cnt = 0;
    raddr = a; raddr_valid = 1'b1;
    while (!raddr_ready && cnt < 50) begin tick(); cnt++; end
    tick();
    raddr_valid = 1'b0;
    lat = 0;
    while (!rdata_valid && lat < 50) begin tick(); lat++; end
    if (!rdata_valid) begin
      n_checks++; n_fail++;
      $display("FAIL read_response: no rdata_valid within %0d cycles", lat);
    end
    d = rdata;
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (raddr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_raddr_ready: got %b need 0", raddr_ready); end
    n_checks++; if (waddr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_waddr_ready: got %b need 0", waddr_ready); end
    n_checks++; if (wdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wdata_ready: got %b need 0", wdata_ready); end
    n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid: got %b need 0", rdata_valid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h need 0", rdata); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (raddr_ready !== 1'b0) begin n_fail++; $display("FAIL unarmed_raddr_ready: got %b need 0", raddr_ready); end
    tick();
    n_checks++; if ({raddr_ready, waddr_ready, wdata_ready} !== 3'b111) begin
      n_fail++; $display("FAIL armed_readies: got %b need 111", {raddr_ready, waddr_ready, wdata_ready});
    end
    model_prio_rd = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] d; int lat;
    wait_idle();
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, d, lat);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_read_data: got %h need deadbeef", d); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_read_latency: got %0d need 2", lat); end
  endtask

  task automatic test_split_write();
    logic [31:0] d; int lat;
    wait_idle();
    wdata = 32'h1234_5678; wdata_valid = 1'b1;
    tick();
    wdata_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wdata_ready !== 1'b0) begin n_fail++; $display("FAIL split_wdata_ready_held: cycle %0d got %b need 0", i, wdata_ready); end
      tick();
    end
    waddr = 32'h0000_0020; waddr_valid = 1'b1;
    n_checks++; if (waddr_ready !== 1'b1) begin n_fail++; $display("FAIL split_waddr_ready: got %b need 1", waddr_ready); end
    tick();
    waddr_valid = 1'b0;
    n_checks++; if ({waddr_ready, wdata_ready} !== 2'b00) begin n_fail++; $display("FAIL split_ready_during_write: got %b need 00", {waddr_ready, wdata_ready}); end
    tick();
    n_checks++; if ({waddr_ready, wdata_ready} !== 2'b11) begin n_fail++; $display("FAIL split_ready_after_write: got %b need 11", {waddr_ready, wdata_ready}); end
    model_mem[word_of(32'h20)] = 32'h1234_5678;
    do_read(32'h0000_0023, d, lat);
    n_checks++; if (d !== model_mem[word_of(32'h23)]) begin n_fail++; $display("FAIL split_read_data: got %h need %h", d, model_mem[word_of(32'h23)]); end
  endtask

  task automatic test_hold();
    logic [31:0] a_val, b_val;
    int cnt, lat;
    a_val = $urandom; b_val = $urandom;
    wait_idle();
    do_write(32'h40, a_val);
    do_write(32'h44, b_val);
    wait_idle();
    raddr = 32'h40; raddr_valid = 1'b1;
    tick();
    raddr_valid = 1'b0;
    cnt = 0;
    while (!rdata_valid && cnt < 20) begin tick(); cnt++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rdata_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: cycle %0d got %b need 1", i, rdata_valid); end
      n_checks++; if (rdata !== a_val) begin n_fail++; $display("FAIL hold_data: cycle %0d got %h need %h", i, rdata, a_val); end
      if (i == 0) begin
        raddr = 32'h44; raddr_valid = 1'b1;
        n_checks++; if (raddr_ready !== 1'b1) begin n_fail++; $display("FAIL hold_second_raddr_ready: got %b need 1", raddr_ready); end
      end
      tick();
      raddr_valid = 1'b0;
    end
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
    n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL hold_gap_after_handshake: got %b need 0", rdata_valid); end
    lat = 0;
    while (!rdata_valid && lat < 20) begin tick(); lat++; end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL hold_queued_latency: got %0d need 2", lat); end
    n_checks++; if (rdata !== b_val) begin n_fail++; $display("FAIL hold_queued_data: got %h need %h", rdata, b_val); end
    rdata_ready = 1'b1;
    tick();
    rdata_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] old_v, new_v, exp_v;
    bit write_first;
    int lat, exp_lat;
    for (int i = 0; i < 4; i++) begin
      old_v = $urandom; new_v = ~old_v;
      wait_idle();
      do_write(32'h80, old_v);
      wait_idle();
      raddr = 32'h80; waddr = 32'h80; wdata = new_v;
      raddr_valid = 1'b1; waddr_valid = 1'b1; wdata_valid = 1'b1;
      n_checks++; if ({raddr_ready, waddr_ready, wdata_ready} !== 3'b111) begin
        n_fail++; $display("FAIL rr_readies: iter %0d got %b need 111", i, {raddr_ready, waddr_ready, wdata_ready});
      end
      tick();
      raddr_valid = 1'b0; waddr_valid = 1'b0; wdata_valid = 1'b0;
      write_first   = !model_prio_rd;
      model_prio_rd = !model_prio_rd;
      exp_v   = write_first ? new_v : old_v;
      exp_lat = write_first ? 3 : 2;
      model_mem[word_of(32'h80)] = new_v;
      lat = 0;
      while (!rdata_valid && lat < 20) begin tick(); lat++; end
      n_checks++; if (rdata !== exp_v) begin n_fail++; $display("FAIL rr_grant_data: iter %0d got %h need %h", i, rdata, exp_v); end
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rr_grant_latency: iter %0d got %0d need %0d", i, lat, exp_lat); end
      rdata_ready = 1'b1;
      tick();
      rdata_ready = 1'b0;
    end
  endtask

  task automatic test_alias();
    logic [31:0] v, d; int lat;
    v = $urandom;
    wait_idle();
    do_write(32'h0000_1004, v);
    do_read(32'h0000_0004, d, lat);
    n_checks++; if (d !== v) begin n_fail++; $display("FAIL alias_low: got %h need %h", d, v); end
    do_read(32'hFFFF_F007, d, lat);
    n_checks++; if (d !== v) begin n_fail++; $display("FAIL alias_high: got %h need %h", d, v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v, d; int cnt, lat;
    v = $urandom;
    wait_idle();
    do_write(32'h100, v);
    wait_idle();
    raddr = 32'h100; raddr_valid = 1'b1;
    tick();
    raddr_valid = 1'b0;
    cnt = 0;
    while (!rdata_valid && cnt < 20) begin tick(); cnt++; end
    n_checks++; if (rdata_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_in_resp: got %b need 1", rdata_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rdata_valid: got %b need 0", rdata_valid); end
    n_checks++; if ({raddr_ready, waddr_ready, wdata_ready} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_readies: got %b need 000", {raddr_ready, waddr_ready, wdata_ready});
    end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h need 0", rdata); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (raddr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_release_ready: got %b need 0", raddr_ready); end
    tick();
    n_checks++; if ({raddr_ready, waddr_ready, wdata_ready} !== 3'b111) begin
      n_fail++; $display("FAIL midrst_rearm: got %b need 111", {raddr_ready, waddr_ready, wdata_ready});
    end
    model_prio_rd = 1'b0;
    do_read(32'h100, d, lat);
    n_checks++; if (d !== v) begin n_fail++; $display("FAIL midrst_retained: got %h need %h", d, v); end
    do_read(32'h10, d, lat);
    n_checks++; if (d !== model_mem[word_of(32'h10)]) begin n_fail++; $display("FAIL midrst_retained_old: got %h need %h", d, model_mem[word_of(32'h10)]); end
  endtask

  task automatic test_random();
    int unsigned written[$];
    int unsigned w;
    logic [31:0] a, d;
    int lat;
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = $urandom; d = $urandom;
        if (!model_valid[word_of(a)]) written.push_back(word_of(a));
        do_write(a, d);
      end else begin
        w = written[$urandom_range(0, written.size() - 1)];
        a = ($urandom & 32'hFFFF_F003) | (w * 4);
        do_read(a, d, lat);
        n_checks++; if (d !== model_mem[w]) begin n_fail++; $display("FAIL random_read_data: addr %h got %h need %h", a, d, model_mem[w]); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL random_read_latency: addr %h got %0d need 2", a, lat); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raddr_valid = 1'b0; raddr = '0;
    rdata_ready = 1'b0;
    waddr_valid = 1'b0; waddr = '0;
    wdata_valid = 1'b0; wdata = '0;
    model_prio_rd = 1'b0;
    for (int i = 0; i < 1024; i++) begin model_mem[i] = '0; model_valid[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_split_write();
    test_hold();
    test_round_robin();
    test_alias();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
